// File: rtl/alu_datapath.sv
// alu_datapath: register file, ALU latches, shared bus and PC driven by ALU control FSM strobes
// Optional feature: define ALU_DP_STATS_EN to build the saturating completed-op counter op_cnt.
module alu_datapath #(
    parameter int WIDTH    = 16,
    parameter int PC_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          opcode,
    input  logic                G0_in,
    input  logic                G1_in,
    input  logic                G2_in,
    input  logic                G3_in,
    input  logic                P0_in,
    input  logic                G0_out,
    input  logic                G1_out,
    input  logic                G2_out,
    input  logic                G3_out,
    input  logic                P0_out,
    input  logic                ALUin1,
    input  logic                ALUin2,
    input  logic                ALU_outlach,
    input  logic                ALU_outEN,
    input  logic                PC_inc,
    input  logic                done,
    input  logic                ld_en,
    input  logic [2:0]          ld_sel,
    input  logic [WIDTH-1:0]    ld_data,
    input  logic [2:0]          dbg_sel,
    output logic [WIDTH-1:0]    dbg_data,
    output logic [WIDTH-1:0]    bus,
    output logic [PC_WIDTH-1:0] pc,
    output logic                flag_z,
    output logic                flag_c,
    output logic                bus_err,
    output logic [7:0]          op_cnt
);
    logic [WIDTH-1:0] g [4];
    logic [WIDTH-1:0] p0, a, b, r;
    logic [WIDTH:0]   alu_full;
    logic             alu_ok;
    logic [3:0]       g_in;

    assign g_in   = {G3_in, G2_in, G1_in, G0_in};
    assign alu_ok = opcode >= 4'b1001;

    // Bus resolution: R wins, then P0 (so the P0_out+G0_out encoding reads P0), then G0..G3
    always_comb begin
        bus = ALU_outEN ? r :
              P0_out    ? p0 :
              G0_out    ? g[0] :
              G1_out    ? g[1] :
              G2_out    ? g[2] :
              G3_out    ? g[3] : '0;
    end

    // Debug read port
    always_comb begin
        dbg_data = !dbg_sel[2]          ? g[dbg_sel[1:0]] :
                   dbg_sel[1:0] == 2'd0 ? p0 :
                   dbg_sel[1:0] == 2'd1 ? a :
                   dbg_sel[1:0] == 2'd2 ? b : r;
    end

    // ALU function with the carry/borrow in the extra top bit
    always_comb begin
        alu_full = {1'b0, r};
        case (opcode)
            4'b1001: alu_full = {1'b0, a} + {1'b0, b};
            4'b1010: alu_full = {1'b0, a} - {1'b0, b};
            4'b1011: alu_full = {1'b0, a & b};
            4'b1100: alu_full = {1'b0, a | b};
            4'b1101: alu_full = {1'b0, a ^ b};
            4'b1110: alu_full = {1'b0, a << b[3:0]};
            4'b1111: alu_full = {1'b0, a >> b[3:0]};
            default: alu_full = {1'b0, r};
        endcase
    end

    // Datapath state: preload beats bus load for the same register; ALU reads pre-edge A/B
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) g[i] <= '0;
            p0      <= '0;
            a       <= '0;
            b       <= '0;
            r       <= '0;
            pc      <= '0;
            flag_z  <= 1'b0;
            flag_c  <= 1'b0;
            bus_err <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (ld_en && ld_sel == 3'(i)) g[i] <= ld_data;
                else if (g_in[i]) g[i] <= bus;
            end
            if (ld_en && ld_sel == 3'd4) p0 <= ld_data;
            else if (P0_in) p0 <= bus;
            if (ALUin1) a <= bus;
            if (ALUin2) b <= bus;
            if (ALU_outlach && alu_ok) begin
                r      <= alu_full[WIDTH-1:0];
                flag_c <= alu_full[WIDTH];
                flag_z <= alu_full[WIDTH-1:0] == '0;
            end
            if (PC_inc) pc <= pc + 1'b1;
            if (ALU_outEN && (G0_out || G1_out || G2_out || G3_out || P0_out)) bus_err <= 1'b1;
        end
    end

`ifdef ALU_DP_STATS_EN
    // Completed-op counter, saturating at all ones
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) op_cnt <= 8'h00;
        else if (done && op_cnt != 8'hFF) op_cnt <= op_cnt + 8'd1;
    end
`else
    logic unused_done;
    assign unused_done = done;
    assign op_cnt      = 8'h00;
`endif
endmodule

// File: tb/tb_alu_datapath.sv
// tb_alu_datapath: directed self-checking bench for alu_datapath
module tb_alu_datapath;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  opcode;
    logic        G0_in, G1_in, G2_in, G3_in, P0_in;
    logic        G0_out, G1_out, G2_out, G3_out, P0_out;
    logic        ALUin1, ALUin2, ALU_outlach, ALU_outEN, PC_inc, done, ld_en;
    logic [2:0]  ld_sel, dbg_sel;
    logic [15:0] ld_data, dbg_data, bus;
    logic [7:0]  pc, op_cnt;
    logic        flag_z, flag_c, bus_err;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] v;
    logic [3:0]  ops [5];
    logic [15:0] res [5];

    alu_datapath dut (
        .clk(clk), .rst(rst), .opcode(opcode),
        .G0_in(G0_in), .G1_in(G1_in), .G2_in(G2_in), .G3_in(G3_in), .P0_in(P0_in),
        .G0_out(G0_out), .G1_out(G1_out), .G2_out(G2_out), .G3_out(G3_out), .P0_out(P0_out),
        .ALUin1(ALUin1), .ALUin2(ALUin2), .ALU_outlach(ALU_outlach), .ALU_outEN(ALU_outEN),
        .PC_inc(PC_inc), .done(done), .ld_en(ld_en), .ld_sel(ld_sel), .ld_data(ld_data),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data), .bus(bus), .pc(pc),
        .flag_z(flag_z), .flag_c(flag_c), .bus_err(bus_err), .op_cnt(op_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        {G0_in, G1_in, G2_in, G3_in, P0_in, G0_out, G1_out, G2_out, G3_out, P0_out} = '0;
        {ALUin1, ALUin2, ALU_outlach, ALU_outEN, PC_inc, done, ld_en} = '0;
        ld_sel = 3'd0;
        ld_data = 16'h0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic preload(input logic [2:0] s, input logic [15:0] d);
        ld_en = 1'b1; ld_sel = s; ld_data = d;
        step();
    endtask

    task automatic rd(input logic [2:0] s, output logic [15:0] d);
        dbg_sel = s;
        #1;
        d = dbg_data;
    endtask

    initial begin
        ops[0] = 4'b1011; res[0] = 16'h0000;
        ops[1] = 4'b1100; res[1] = 16'h01F7;
        ops[2] = 4'b1101; res[2] = 16'h01F7;
        ops[3] = 4'b1110; res[3] = 16'h0F30;
        ops[4] = 4'b1111; res[4] = 16'h000F;
        idle();
        opcode = 4'b0000;
        dbg_sel = 3'd0;
        #12 rst = 1'b1;
        @(posedge clk); #1;

        // reset mid-instruction with random strobes
        preload(3'd0, 16'h1234);
        PC_inc = 1'b1; step();
        {G0_in, G1_in, G2_in, G3_in, P0_in, G0_out, G1_out, P0_out, ALUin1, ALUin2} = 10'($urandom);
        ALU_outlach = 1'b1; opcode = 4'b1001; PC_inc = 1'b1; done = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("rst_pc", pc, 0);
        chk("rst_bus", bus, 0);
        chk("rst_flags", {flag_z, flag_c, bus_err}, 0);
        chk("rst_opcnt", op_cnt, 0);
        @(posedge clk); #1;
        idle();
        for (int i = 0; i < 8; i++) begin
            rd(3'(i), v);
            chk("rst_reg", v, 0);
        end
        chk("rst_bus_idle", bus, 0);
        rst = 1'b1;
        opcode = 4'b0000;

        // ADD 5+3 written back into G1
        preload(3'd1, 16'h0005);
        preload(3'd2, 16'h0003);
        G1_out = 1'b1; ALUin1 = 1'b1; step();
        G2_out = 1'b1; ALUin2 = 1'b1; step();
        opcode = 4'b1001; ALU_outlach = 1'b1; step();
        ALU_outEN = 1'b1; G1_in = 1'b1;
        #1 chk("add_bus", bus, 16'h0008);
        step();
        rd(3'd1, v); chk("add_g1", v, 16'h0008);
        chk("add_flags", {flag_z, flag_c}, 2'b00);
        chk("add_err", bus_err, 0);

        // SUB to zero, then SUB with borrow
        preload(3'd0, 16'h0003);
        G0_out = 1'b1; ALUin1 = 1'b1; ALUin2 = 1'b1; step();
        opcode = 4'b1010; ALU_outlach = 1'b1; step();
        rd(3'd7, v); chk("sub0_r", v, 16'h0000);
        chk("sub0_flags", {flag_z, flag_c}, 2'b10);
        preload(3'd0, 16'h0002);
        preload(3'd1, 16'h0003);
        G0_out = 1'b1; ALUin1 = 1'b1; step();
        G1_out = 1'b1; ALUin2 = 1'b1; step();
        ALU_outlach = 1'b1; step();
        rd(3'd7, v); chk("subb_r", v, 16'hFFFF);
        chk("subb_flags", {flag_z, flag_c}, 2'b01);

        // ADD with carry out and zero result
        preload(3'd0, 16'hFFFF);
        preload(3'd1, 16'h0001);
        G0_out = 1'b1; ALUin1 = 1'b1; step();
        G1_out = 1'b1; ALUin2 = 1'b1; step();
        opcode = 4'b1001; ALU_outlach = 1'b1; step();
        rd(3'd7, v); chk("addc_r", v, 16'h0000);
        chk("addc_flags", {flag_z, flag_c}, 2'b11);

        // logic and shift ops clear carry
        preload(3'd2, 16'h00F3);
        preload(3'd3, 16'h0104);
        G2_out = 1'b1; ALUin1 = 1'b1; step();
        G3_out = 1'b1; ALUin2 = 1'b1; step();
        for (int i = 0; i < 5; i++) begin
            opcode = ops[i]; ALU_outlach = 1'b1; step();
            rd(3'd7, v); chk("logic_r", v, res[i]);
            chk("logic_flags", {flag_z, flag_c}, {res[i] == 16'h0, 1'b0});
        end

        // simultaneous ALUin1 and latch uses old A
        preload(3'd0, 16'h0001);
        opcode = 4'b1001; G0_out = 1'b1; ALUin1 = 1'b1; ALU_outlach = 1'b1; step();
        rd(3'd7, v); chk("oldA_r", v, 16'h01F7);
        rd(3'd5, v); chk("oldA_a", v, 16'h0001);
        ALU_outEN = 1'b1; ALU_outlach = 1'b1;
        #1 chk("oldR_bus", bus, 16'h01F7);
        step();
        rd(3'd7, v); chk("newR", v, 16'h0105);
        chk("noerr_alone", bus_err, 0);

        // bus priority, preload override, bus_err stickiness
        preload(3'd4, 16'hAAAA);
        preload(3'd0, 16'h5555);
        P0_out = 1'b1; G0_out = 1'b1;
        #1 chk("p0g0_bus", bus, 16'hAAAA);
        step();
        chk("p0g0_err", bus_err, 0);
        P0_out = 1'b1; G0_in = 1'b1; G1_in = 1'b1; ld_en = 1'b1; ld_sel = 3'd0; ld_data = 16'h1357;
        step();
        rd(3'd0, v); chk("ld_override", v, 16'h1357);
        rd(3'd1, v); chk("multi_load", v, 16'hAAAA);
        G1_out = 1'b1; G2_out = 1'b1;
        #1 chk("g1_over_g2", bus, 16'hAAAA);
        idle();
        G2_out = 1'b1; G3_out = 1'b1;
        #1 chk("g2_over_g3", bus, 16'h00F3);
        idle();
        #1 chk("bus_none", bus, 0);
        G1_out = 1'b1; G1_in = 1'b1; step();
        rd(3'd1, v); chk("self_reload", v, 16'hAAAA);
        ALU_outEN = 1'b1; G2_out = 1'b1;
        #1 chk("rout_bus", bus, 16'h0105);
        step();
        chk("err_set", bus_err, 1);
        step(); step();
        chk("err_sticky", bus_err, 1);

        // PC wrap and invalid opcode
        for (int i = 0; i < 254; i++) begin
            PC_inc = 1'b1; step();
        end
        chk("pc_fe", pc, 8'hFE);
        PC_inc = 1'b1; step();
        chk("pc_ff", pc, 8'hFF);
        PC_inc = 1'b1; step();
        chk("pc_wrap", pc, 8'h00);
        opcode = 4'b0011; ALU_outlach = 1'b1; step();
        rd(3'd7, v); chk("badop_r", v, 16'h0105);
        chk("badop_flags", {flag_z, flag_c}, 2'b00);
        opcode = 4'b1000; ALU_outlach = 1'b1; step();
        rd(3'd7, v); chk("op1000_r", v, 16'h0105);

        // completed-op counter
        for (int i = 0; i < 10; i++) begin
            done = 1'b1; step();
        end
`ifdef ALU_DP_STATS_EN
        chk("opcnt_10", op_cnt, 8'd10);
`else
        chk("opcnt_10", op_cnt, 8'd0);
`endif
        rd(3'd7, v); chk("done_noeffect", v, 16'h0105);
        for (int i = 0; i < 290; i++) begin
            done = 1'b1; step();
        end
`ifdef ALU_DP_STATS_EN
        chk("opcnt_sat", op_cnt, 8'hFF);
`else
        chk("opcnt_sat", op_cnt, 8'h00);
`endif
        chk("done_pc", pc, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
